// File: rtl/trax_pkg.sv
// trax_pkg: shared Trax move-word layout, tile codes and ASCII constants
// used by the move transmitter, the receive path and the game engine.
package trax_pkg;
    typedef enum logic [1:0] {
        TILE_EMPTY  = 2'b00,
        TILE_PLUS   = 2'b01,
        TILE_SLASH  = 2'b10,
        TILE_BSLASH = 2'b11
    } tile_t;

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_BCD, S_SEND} tx_state_t;

    localparam int MAX_ROW      = 20;
    localparam int MAX_COL      = 20;
    localparam int MOVE_W       = 22;
    localparam int TILE_LSB     = 20;
    localparam int COL_LSB      = 10;
    localparam int ROW_LSB      = 0;
    localparam int FIELD_W      = 10;
    localparam int MAX_COL_CHAR = 26;
    localparam int DD_STEPS     = 10;

    localparam logic [7:0] ASCII_AT     = 8'h40;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;
    localparam logic [7:0] ASCII_PLUS   = 8'h2B;
    localparam logic [7:0] ASCII_SLASH  = 8'h2F;
    localparam logic [7:0] ASCII_BSLASH = 8'h5C;
    localparam logic [7:0] ASCII_LF     = 8'h0A;

    function automatic logic [7:0] tile_char(input logic [1:0] t);
        return t == TILE_PLUS ? ASCII_PLUS : t == TILE_SLASH ? ASCII_SLASH : ASCII_BSLASH;
    endfunction

    // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift.
    function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int i = 0; i < 4; i++)
            r[4*i +: 4] = b[4*i +: 4] >= 4'd5 ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        return r;
    endfunction
endpackage

// File: rtl/trax_move_tx_uart.sv
// uart_tx_byte: 8N1 byte serializer with load/ready handshake; ready is also
// high on the last cycle of a stop bit so bytes can be chained with no gap.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    output logic       o_ready,
    output logic       o_tx
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] LAST = BW'(CLKS_PER_BIT - 1);

    logic          r_active;
    logic [BW-1:0] r_baud;
    logic [3:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic          w_end;

    assign w_end   = r_baud == LAST;
    assign o_ready = !r_active || (r_bit == 4'd9 && w_end);
    assign o_tx    = r_tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
        end else if (i_load && o_ready) begin
            r_active <= 1'b1;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= i_byte;
            r_tx     <= 1'b0;
        end else if (r_active) begin
            if (w_end) begin
                r_baud <= '0;
                if (r_bit == 4'd9) begin
                    r_active <= 1'b0;
                    r_tx     <= 1'b1;
                end else begin
                    r_bit   <= r_bit + 4'd1;
                    r_tx    <= r_bit == 4'd8 ? 1'b1 : r_shift[0];
                    r_shift <= r_shift >> 1;
                end
            end else begin
                r_baud <= r_baud + BW'(1);
            end
        end
    end
endmodule

// File: rtl/trax_move_tx.sv
// trax_move_tx: validates a 22-bit Trax move, converts the row to decimal and
// sends "<col><row digits><tile>\n" over an 8N1 UART line.
module trax_move_tx
    import trax_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_transmit,
    input  logic [21:0] move_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        tx
);
    tx_state_t   r_state, w_next;
    logic [21:0] r_move;
    logic [15:0] r_bcd, w_adj;
    logic [9:0]  r_bin;
    logic [3:0]  r_cnt;
    logic [2:0]  r_idx, w_ndig, w_nbytes;
    logic [1:0]  w_lead, w_dsel, w_tile;
    logic [9:0]  w_col;
    logic [3:0]  w_digit;
    logic [7:0]  w_byte;
    logic        w_valid, w_load, w_fin, w_ready, w_accept;
    logic        r_done, r_err;

    assign w_tile   = r_move[TILE_LSB +: 2];
    assign w_col    = r_move[COL_LSB +: FIELD_W];
    assign w_valid  = w_tile != TILE_EMPTY && w_col <= 10'(MAX_COL_CHAR);
    assign w_accept = r_state == S_IDLE && start_transmit && !r_done;
    assign w_adj    = bcd_adjust(r_bcd);

    // Leading digit: first nonzero nibble from the top; units if the row is 0.
    assign w_lead   = |r_bcd[15:12] ? 2'd3 : |r_bcd[11:8] ? 2'd2 : |r_bcd[7:4] ? 2'd1 : 2'd0;
    assign w_ndig   = {1'b0, w_lead} + 3'd1;
    assign w_nbytes = w_ndig + 3'd3;
    assign w_dsel   = w_lead + 2'd1 - r_idx[1:0];
    assign w_digit  = r_bcd[{w_dsel, 2'b00} +: 4];
    assign w_byte   = r_idx == 3'd0             ? ASCII_AT + {3'b000, w_col[4:0]} :
                      r_idx == w_ndig + 3'd1    ? tile_char(w_tile) :
                      r_idx == w_ndig + 3'd2    ? ASCII_LF :
                                                  ASCII_ZERO + {4'b0000, w_digit};

    // busy also covers the done cycle so a request coinciding with done is ignored.
    assign busy = r_state != S_IDLE || r_done;
    assign done = r_done;
    assign err  = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_fin  = 1'b0;
        case (r_state)
            S_IDLE:  w_next = w_accept ? S_CHECK : S_IDLE;
            S_CHECK: w_next = w_valid ? S_BCD : S_IDLE;
            S_BCD:   w_next = r_cnt == 4'(DD_STEPS - 1) ? S_SEND : S_BCD;
            S_SEND: begin
                w_fin  = w_ready && r_idx == w_nbytes;
                w_load = w_ready && r_idx != w_nbytes;
                w_next = w_fin ? S_IDLE : S_SEND;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_move <= '0;
            r_bcd  <= '0;
            r_bin  <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_fin;
            r_err  <= r_state == S_CHECK && !w_valid;
            if (w_accept) r_move <= move_in;
            if (r_state == S_CHECK) begin
                r_bcd <= '0;
                r_bin <= r_move[ROW_LSB +: FIELD_W];
                r_cnt <= '0;
                r_idx <= '0;
            end
            if (r_state == S_BCD) begin
                r_bcd <= 16'({w_adj, r_bin[9]});
                r_bin <= r_bin << 1;
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_load) r_idx <= r_idx + 3'd1;
        end
    end

    uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
        .clk     (clk),
        .rst_n   (reset),
        .i_load  (w_load),
        .i_byte  (w_byte),
        .o_ready (w_ready),
        .o_tx    (tx)
    );
endmodule

// File: tb/tb_trax_move_tx.sv
// tb_trax_move_tx: directed frames with hand-computed bytes, decoded from the
// tx line by a negedge-sampling monitor.
module tb_trax_move_tx;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        reset, start_transmit;
    logic [21:0] move_in;
    logic        busy, done, err, tx;

    trax_move_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk            (clk),
        .reset          (reset),
        .start_transmit (start_transmit),
        .move_in        (move_in),
        .busy           (busy),
        .done           (done),
        .err            (err),
        .tx             (tx)
    );

    always #5 clk = ~clk;

    int         n_chk = 0, n_fail = 0, cyc = 0, c0 = 0;
    int         busy_cnt = 0, done_cnt = 0, err_cnt = 0, bad_stop = 0, err_t = -1;
    int         mon_cnt = 0;
    logic       mon_act = 1'b0;
    logic [7:0] mon_sh = '0;
    logic [7:0] rx_q[$];
    int         start_t[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Bit b of a byte spans monitor counts 4b..4b+3; sample each bit mid-period.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (err) begin err_cnt++; err_t = cyc; end
        if (!reset) mon_act = 1'b0;
        else if (!mon_act) begin
            if (!tx) begin mon_act = 1'b1; mon_cnt = 0; start_t.push_back(cyc); end
        end else begin
            mon_cnt++;
            if (mon_cnt >= 6 && mon_cnt <= 34 && mon_cnt % 4 == 2) mon_sh = {tx, mon_sh[7:1]};
            if (mon_cnt == 38) begin
                if (!tx) bad_stop++;
                rx_q.push_back(mon_sh);
                mon_act = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [21:0] m);
        @(posedge clk);
        busy_cnt = 0; done_cnt = 0; err_cnt = 0; bad_stop = 0; err_t = -1;
        rx_q.delete();
        start_t.delete();
        @(negedge clk);
        start_transmit = 1'b1;
        move_in = m;
        @(negedge clk);
        c0 = cyc;
        start_transmit = 1'b0;
        move_in = '0;
    endtask

    task automatic check_frame(input string tag, input logic [55:0] exp, input int n);
        int bad_gap;
        for (int i = 0; i < 600 && done_cnt == 0; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        chk({tag, "_done"}, done_cnt, 1);
        chk({tag, "_busy"}, busy_cnt, 13 + 10 * CPB * n);
        chk({tag, "_nbytes"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), {24'h0, rx_q[i]}, {24'h0, exp[8*(n-1-i) +: 8]});
        chk({tag, "_first_start"}, start_t.size() > 0 ? start_t[0] : -1, c0 + 12);
        bad_gap = 0;
        for (int i = 1; i < start_t.size(); i++)
            if (start_t[i] - start_t[i-1] != 10 * CPB) bad_gap++;
        chk({tag, "_gap"}, bad_gap, 0);
        chk({tag, "_stop"}, bad_stop, 0);
        chk({tag, "_err"}, err_cnt, 0);
        chk({tag, "_tx_idle"}, tx, 1);
    endtask

    task automatic check_invalid(input string tag, input logic [21:0] m);
        launch(m);
        repeat (8 * CPB) @(negedge clk);
        chk({tag, "_err_cnt"}, err_cnt, 1);
        chk({tag, "_err_time"}, err_t, c0 + 1);
        chk({tag, "_busy"}, busy_cnt, 1);
        chk({tag, "_done"}, done_cnt, 0);
        chk({tag, "_tx_quiet"}, start_t.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        start_transmit = 1'b0;
        move_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        launch({2'b01, 10'd0, 10'd0});
        check_frame("plus_c0_r0", 56'h40302B0A, 4);

        launch({2'b10, 10'd3, 10'd12});
        check_frame("slash_c3_r12", 56'h4331322F0A, 5);

        launch({2'b11, 10'd26, 10'd1023});
        check_frame("bslash_c26_r1023", 56'h5A313032335C0A, 7);

        launch({2'b01, 10'd1, 10'd100});
        check_frame("plus_c1_r100", 56'h413130302B0A, 6);

        check_invalid("tile_empty", {2'b00, 10'd4, 10'd5});
        check_invalid("col27", {2'b01, 10'd27, 10'd5});

        launch({2'b10, 10'd9, 10'd7});
        check_frame("after_invalid", 56'h49372F0A, 4);

        launch({2'b01, 10'd5, 10'd7});
        repeat (50) @(negedge clk);
        start_transmit = 1'b1;
        move_in = {2'b10, 10'd2, 10'd99};
        @(negedge clk);
        start_transmit = 1'b0;
        move_in = '0;
        check_frame("ignore_mid", 56'h45372B0A, 4);

        launch({2'b11, 10'd2, 10'd5});
        repeat (30) @(negedge clk);
        chk("pre_reset_tx_low", tx, 0);
        #2 reset = 1'b0;
        #1;
        chk("async_reset_tx", tx, 1);
        chk("async_reset_busy", busy, 0);
        chk("async_reset_done", done, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        launch({2'b11, 10'd2, 10'd5});
        check_frame("after_reset", 56'h42355C0A, 4);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
